// File: rtl/ah_pkt_pkg.sv
// Shared helpers for the ah packet converters: width arithmetic and lane derivation.
package ah_pkt_pkg;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Index width that never collapses to zero bits, even for a single entry.
  function automatic int idx_width(input int entries);
    return (entries > 1) ? clog2(entries) : 1;
  endfunction

  function automatic int nlanes(input int in_w, input int out_w);
    return ceil_div(in_w, out_w);
  endfunction

  function automatic int credit_width(input int credit_max);
    return clog2(credit_max + 1);
  endfunction

endpackage

// File: rtl/ah_fifo_sync.sv
// Small synchronous FIFO with full/empty flags; push is accepted at full when a pop
// happens in the same cycle, so occupancy stays unchanged.
module ah_fifo_sync
  import ah_pkt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = idx_width(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign rdata_o   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ah_packet_converter_w2n.sv
// Wide-to-narrow converter: buffers IN_W words and emits them as NLANES OUT_W-bit beats,
// least-significant lane first, under credit flow control on both sides.
module ah_packet_converter_w2n
  import ah_pkt_pkg::*;
#(
  parameter int IN_W         = 32,
  parameter int OUT_W        = 20,
  parameter int DEPTH        = 2,
  parameter int RCREDIT_INIT = 4,
  parameter int CREDIT_MAX   = 15
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IN_W-1:0]  wdata,
  input  logic             wvalid,
  output logic             wcredit,
  output logic [OUT_W-1:0] rdata,
  output logic             rvalid,
  input  logic             rcredit,
  output logic             err_ovf,
  output logic             err_cred
);

  localparam int NLANES = nlanes(IN_W, OUT_W);
  localparam int LW     = idx_width(NLANES);
  localparam int CRW    = credit_width(CREDIT_MAX);
  localparam int PAD_W  = NLANES * OUT_W;

  logic [IN_W-1:0]  head_s;
  logic [PAD_W-1:0] head_pad_s;
  logic [OUT_W-1:0] lane_data_s;
  logic             full_s, empty_s;
  logic             issue_s, last_lane_s, pop_s, ovf_s, sat_s;

  logic [LW-1:0]    lane_q, lane_d;
  logic [CRW-1:0]   credit_q, credit_d;
  logic [OUT_W-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             wcredit_q, wcredit_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_cred_q, err_cred_d;

  ah_fifo_sync #(
    .WIDTH (IN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (wvalid),
    .pop_i   (pop_s),
    .wdata_i (wdata),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Zero-extend the head so the top lane reads zeros above IN_W-1.
  assign head_pad_s  = PAD_W'(head_s);
  assign lane_data_s = head_pad_s[lane_q*OUT_W +: OUT_W];
  assign issue_s     = !empty_s && (credit_q != '0);
  assign last_lane_s = (lane_q == LW'(NLANES - 1));
  assign pop_s       = issue_s && last_lane_s;
  assign ovf_s       = wvalid && full_s && !pop_s;

  always_comb begin
    lane_d   = lane_q;
    credit_d = credit_q;
    sat_s    = 1'b0;
    if (issue_s) begin
      lane_d = last_lane_s ? '0 : lane_q + LW'(1);
    end else begin
      lane_d = lane_q;
    end
    // A returned credit and a spent credit in the same cycle cancel out.
    if (rcredit && issue_s) begin
      credit_d = credit_q;
    end else if (rcredit) begin
      if (credit_q == CRW'(CREDIT_MAX)) begin
        sat_s = 1'b1;
      end else begin
        credit_d = credit_q + CRW'(1);
      end
    end else if (issue_s) begin
      credit_d = credit_q - CRW'(1);
    end else begin
      credit_d = credit_q;
    end
    rdata_d    = issue_s ? lane_data_s : rdata_q;
    rvalid_d   = issue_s;
    wcredit_d  = pop_s;
    err_ovf_d  = err_ovf_q | ovf_s;
    err_cred_d = err_cred_q | sat_s;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_q     <= '0;
      credit_q   <= CRW'(RCREDIT_INIT);
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      wcredit_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_cred_q <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      credit_q   <= credit_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      wcredit_q  <= wcredit_d;
      err_ovf_q  <= err_ovf_d;
      err_cred_q <= err_cred_d;
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign wcredit  = wcredit_q;
  assign err_ovf  = err_ovf_q;
  assign err_cred = err_cred_q;

endmodule

// File: tb/tb_ah_packet_converter_w2n.sv
// Directed bench: instance A uses default parameters, instance B starts with one output credit.
module tb_ah_packet_converter_w2n;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] a_wdata, b_wdata;
  logic        a_wvalid, b_wvalid;
  logic        a_wcredit, b_wcredit;
  logic [19:0] a_rdata, b_rdata;
  logic        a_rvalid, b_rvalid;
  logic        a_rcredit, b_rcredit;
  logic        a_err_ovf, b_err_ovf;
  logic        a_err_cred, b_err_cred;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] words [8];
  logic [19:0] beats_q [$];
  int          beat_cyc [$];
  int          wcr_cnt;

  always #5 clk = ~clk;

  ah_packet_converter_w2n u_dut_a (
    .clk (clk), .rstn (rstn), .wdata (a_wdata), .wvalid (a_wvalid), .wcredit (a_wcredit),
    .rdata (a_rdata), .rvalid (a_rvalid), .rcredit (a_rcredit),
    .err_ovf (a_err_ovf), .err_cred (a_err_cred)
  );

  ah_packet_converter_w2n #(.RCREDIT_INIT(1)) u_dut_b (
    .clk (clk), .rstn (rstn), .wdata (b_wdata), .wvalid (b_wvalid), .wcredit (b_wcredit),
    .rdata (b_rdata), .rvalid (b_rvalid), .rcredit (b_rcredit),
    .err_ovf (b_err_ovf), .err_cred (b_err_cred)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_wvalid = 1'b0; a_wdata = '0; a_rcredit = 1'b0;
    b_wvalid = 1'b0; b_wdata = '0; b_rcredit = 1'b0;
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  function automatic logic [31:0] beat_at(input int k);
    return (k < beats_q.size()) ? 32'(beats_q[k]) : 32'hFFFF_FFFF;
  endfunction

  // Upstream on A honours its DEPTH credits; optionally downstream echoes one credit per beat.
  task automatic run_a(input int nwords, input bit echo, input int ncyc);
    int sent;
    int ucred;
    sent = 0;
    ucred = 2;
    beats_q.delete();
    beat_cyc.delete();
    wcr_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      a_rcredit = echo && a_rvalid;
      if (a_rvalid) begin
        beats_q.push_back(a_rdata);
        beat_cyc.push_back(c);
      end
      if (a_wcredit) begin
        ucred++;
        wcr_cnt++;
      end
      if (sent < nwords && ucred > 0) begin
        a_wvalid = 1'b1;
        a_wdata  = words[sent];
        sent++;
        ucred--;
      end else begin
        a_wvalid = 1'b0;
      end
      step();
    end
    a_wvalid  = 1'b0;
    a_rcredit = 1'b0;
  endtask

  initial begin
    logic [19:0] exp_stream [8];
    logic [31:0] ow [3];
    do_reset();

    check("reset rdata", 32'(a_rdata), 32'h0);
    check("reset rvalid", 32'(a_rvalid), 32'h0);
    check("reset wcredit", 32'(a_wcredit), 32'h0);
    check("reset err_ovf", 32'(a_err_ovf), 32'h0);
    check("reset err_cred", 32'(a_err_cred), 32'h0);

    // Single word
    a_wvalid = 1'b1; a_wdata = 32'hDEADBEEF;
    step();
    a_wvalid = 1'b0;
    check("single N+1 rvalid", 32'(a_rvalid), 32'h0);
    step();
    check("single N+2 rvalid", 32'(a_rvalid), 32'h1);
    check("single lane0", 32'(a_rdata), 32'h000DBEEF);
    check("single N+2 wcredit", 32'(a_wcredit), 32'h0);
    step();
    check("single N+3 rvalid", 32'(a_rvalid), 32'h1);
    check("single lane1", 32'(a_rdata), 32'h00000DEA);
    check("single wcredit pulse", 32'(a_wcredit), 32'h1);
    step();
    check("single N+4 rvalid", 32'(a_rvalid), 32'h0);
    check("single N+4 wcredit", 32'(a_wcredit), 32'h0);
    check("single rdata hold", 32'(a_rdata), 32'h00000DEA);

    // Credit starvation on B
    do_reset();
    b_wvalid = 1'b1; b_wdata = 32'h12345678;
    step();
    b_wvalid = 1'b0;
    step();
    check("starve lane0 rvalid", 32'(b_rvalid), 32'h1);
    check("starve lane0", 32'(b_rdata), 32'h00045678);
    step();
    check("starve stall rvalid", 32'(b_rvalid), 32'h0);
    step();
    check("starve stall2 rvalid", 32'(b_rvalid), 32'h0);
    check("starve no wcredit", 32'(b_wcredit), 32'h0);
    b_rcredit = 1'b1;
    step();
    b_rcredit = 1'b0;
    check("starve resume M+1 rvalid", 32'(b_rvalid), 32'h0);
    step();
    check("starve resume rvalid", 32'(b_rvalid), 32'h1);
    check("starve lane1", 32'(b_rdata), 32'h00000123);
    check("starve wcredit", 32'(b_wcredit), 32'h1);

    // Streaming on A
    do_reset();
    words[0] = 32'h11112222; words[1] = 32'hAAAA5555;
    words[2] = 32'h0F0F0F0F; words[3] = 32'hCAFEF00D;
    exp_stream[0] = 20'h12222; exp_stream[1] = 20'h00111;
    exp_stream[2] = 20'hA5555; exp_stream[3] = 20'h00AAA;
    exp_stream[4] = 20'hF0F0F; exp_stream[5] = 20'h000F0;
    exp_stream[6] = 20'hEF00D; exp_stream[7] = 20'h00CAF;
    run_a(4, 1'b1, 20);
    check("stream beat count", 32'(beats_q.size()), 32'd8);
    for (int k = 0; k < 8; k++) check($sformatf("stream beat %0d", k), beat_at(k), 32'(exp_stream[k]));
    check("stream first beat cycle", 32'(beat_cyc[0]), 32'd2);
    check("stream span", 32'(beat_cyc[beat_cyc.size()-1] - beat_cyc[0]), 32'd7);
    check("stream wcredit count", 32'(wcr_cnt), 32'd4);
    check("stream err_ovf", 32'(a_err_ovf), 32'h0);
    check("stream err_cred", 32'(a_err_cred), 32'h0);

    // Overflow on B: one credit, three back-to-back words
    do_reset();
    ow[0] = 32'h76543210; ow[1] = 32'h89ABCDEF; ow[2] = 32'hFFFFFFFF;
    beats_q.delete();
    for (int c = 0; c < 12; c++) begin
      b_wvalid  = (c < 3);
      b_wdata   = (c < 3) ? ow[c] : 32'h0;
      b_rcredit = (c >= 4 && c < 10);
      if (b_rvalid) beats_q.push_back(b_rdata);
      if (c == 3) check("ovf flag", 32'(b_err_ovf), 32'h1);
      if (c == 2) check("ovf not yet", 32'(b_err_ovf), 32'h0);
      step();
    end
    b_wvalid = 1'b0; b_rcredit = 1'b0;
    check("ovf beat count", 32'(beats_q.size()), 32'd4);
    check("ovf beat 0", beat_at(0), 32'h00043210);
    check("ovf beat 1", beat_at(1), 32'h00000765);
    check("ovf beat 2", beat_at(2), 32'h000BCDEF);
    check("ovf beat 3", beat_at(3), 32'h0000089A);
    check("ovf sticky", 32'(b_err_ovf), 32'h1);
    check("ovf err_cred", 32'(b_err_cred), 32'h0);

    // Credit saturation on A
    do_reset();
    a_rcredit = 1'b1;
    for (int i = 0; i < 11; i++) step();
    check("sat at 15 no err", 32'(a_err_cred), 32'h0);
    step();
    a_rcredit = 1'b0;
    check("sat err_cred", 32'(a_err_cred), 32'h1);
    words[4] = 32'h01234567; words[5] = 32'h89ABCDEF;
    words[6] = 32'h55AA55AA; words[7] = 32'h0BADF00D;
    run_a(8, 1'b0, 40);
    check("sat beat count", 32'(beats_q.size()), 32'd15);
    check("sat last beat", beat_at(14), 32'h000DF00D);
    check("sat err sticky", 32'(a_err_cred), 32'h1);

    // Reset mid-word on A
    do_reset();
    a_wvalid = 1'b1; a_wdata = 32'hDEADBEEF;
    step();
    a_wvalid = 1'b0;
    step();
    check("midrst lane0", 32'(a_rdata), 32'h000DBEEF);
    rstn = 1'b0;
    #1;
    check("midrst rdata", 32'(a_rdata), 32'h0);
    check("midrst rvalid", 32'(a_rvalid), 32'h0);
    check("midrst wcredit", 32'(a_wcredit), 32'h0);
    step();
    step();
    rstn = 1'b1;
    words[0] = 32'h13572468; words[1] = 32'h2468ACE0; words[2] = 32'h0BADF00D;
    run_a(3, 1'b0, 20);
    check("midrst beat count", 32'(beats_q.size()), 32'd4);
    check("midrst first cycle", 32'(beat_cyc[0]), 32'd2);
    check("midrst beat 0", beat_at(0), 32'h00072468);
    check("midrst beat 1", beat_at(1), 32'h00000135);
    check("midrst beat 2", beat_at(2), 32'h0008ACE0);
    check("midrst beat 3", beat_at(3), 32'h00000246);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
